// File: rtl/control_step_sequencer_if.sv
// Datapath control bundle between the step sequencer and the five-stage datapath.
// Inputs to the sequencer: ProcessorEnable, InstrClass, BranchTaken, MFC.
// Outputs from the sequencer: register enables, mux selects, memory strobes,
// ClockCount, OperationFinished and Fault.
// master = sequencer side, slave = datapath side.
interface control_step_sequencer_if;
  logic       ProcessorEnable;
  logic [2:0] InstrClass;
  logic       BranchTaken;
  logic       MFC;

  logic       ROM_Read;
  logic       IR_Enable;
  logic       PC_Enable;
  logic       PC_Select;
  logic       INC_Select;
  logic       RA_Enable;
  logic       RB_Enable;
  logic       B_Select;
  logic       RZ_Enable;
  logic       RM_Enable;
  logic       CCR_Enable;
  logic       MemRequest;
  logic       MEM_Read_H_Write_L;
  logic       RY_Enable;
  logic       RF_WRITE;
  logic [1:0] C_Select;
  logic [1:0] Y_Select;
  logic [2:0] ClockCount;
  logic       OperationFinished;
  logic       Fault;

  modport master (
    input  ProcessorEnable, InstrClass, BranchTaken, MFC,
    output ROM_Read, IR_Enable, PC_Enable, PC_Select, INC_Select,
           RA_Enable, RB_Enable, B_Select, RZ_Enable, RM_Enable, CCR_Enable,
           MemRequest, MEM_Read_H_Write_L, RY_Enable, RF_WRITE,
           C_Select, Y_Select, ClockCount, OperationFinished, Fault
  );

  modport slave (
    output ProcessorEnable, InstrClass, BranchTaken, MFC,
    input  ROM_Read, IR_Enable, PC_Enable, PC_Select, INC_Select,
           RA_Enable, RB_Enable, B_Select, RZ_Enable, RM_Enable, CCR_Enable,
           MemRequest, MEM_Read_H_Write_L, RY_Enable, RF_WRITE,
           C_Select, Y_Select, ClockCount, OperationFinished, Fault
  );
endinterface

// File: rtl/control_step_sequencer.sv
// Multicycle control-step sequencer (Fetch, Decode, Execute, Memory, Write Back).
// Ports:
//   Clock          - rising-edge clock
//   ProcessorReset - asynchronous active-high reset
//   bus            - control_step_sequencer_if.master (run switch, instruction
//                    class, branch flag, MFC in; datapath controls out)
// Outputs are a Moore decode of the state register, except the LOAD RY_Enable
// and the S4 exit, which follow MFC combinationally.
// Optional: define CSG_MEM_TIMEOUT_EN to halt after TIMEOUT_CYCLES S4 cycles
// without MFC on a memory instruction.
module control_step_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                       Clock,
  input logic                       ProcessorReset,
  control_step_sequencer_if.master  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S1   = 3'd1;
  localparam logic [2:0] S2   = 3'd2;
  localparam logic [2:0] S3   = 3'd3;
  localparam logic [2:0] S4   = 3'd4;
  localparam logic [2:0] S5   = 3'd5;
  localparam logic [2:0] HALT = 3'd6;

  localparam logic [2:0] CLS_ALU_REG = 3'd0;
  localparam logic [2:0] CLS_ALU_IMM = 3'd1;
  localparam logic [2:0] CLS_LOAD    = 3'd2;
  localparam logic [2:0] CLS_STORE   = 3'd3;
  localparam logic [2:0] CLS_BRANCH  = 3'd4;
  localparam logic [2:0] CLS_CALL    = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("control_step_sequencer: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [2:0] state_q, state_d;
  logic       mem_wait;

`ifdef CSG_MEM_TIMEOUT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;
`endif

  // State register (and stall counter when the timeout is built in)
  always_ff @(posedge Clock or posedge ProcessorReset) begin
    if (ProcessorReset) begin
      state_q <= IDLE;
`ifdef CSG_MEM_TIMEOUT_EN
      stall_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CSG_MEM_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d                = state_q;
    mem_wait               = 1'b0;
`ifdef CSG_MEM_TIMEOUT_EN
    stall_cnt_d            = stall_cnt_q;
`endif
    bus.ROM_Read           = 1'b0;
    bus.IR_Enable          = 1'b0;
    bus.PC_Enable          = 1'b0;
    bus.PC_Select          = 1'b0;
    bus.INC_Select         = 1'b0;
    bus.RA_Enable          = 1'b0;
    bus.RB_Enable          = 1'b0;
    bus.B_Select           = 1'b0;
    bus.RZ_Enable          = 1'b0;
    bus.RM_Enable          = 1'b0;
    bus.CCR_Enable         = 1'b0;
    bus.MemRequest         = 1'b0;
    bus.MEM_Read_H_Write_L = 1'b0;
    bus.RY_Enable          = 1'b0;
    bus.RF_WRITE           = 1'b0;
    bus.C_Select           = 2'd0;
    bus.Y_Select           = 2'd0;
    bus.OperationFinished  = 1'b0;
    bus.Fault              = 1'b0;
    // Step number equals the state code for S1..S5; IDLE/HALT report 0
    bus.ClockCount         = (state_q <= S5) ? state_q : 3'd0;

    case (state_q)
      IDLE: begin
        if (bus.ProcessorEnable) state_d = S1;
      end

      S1: begin
        bus.ROM_Read  = 1'b1;
        bus.IR_Enable = 1'b1;
        bus.PC_Enable = 1'b1;
        state_d       = S2;
      end

      S2: begin
        bus.RA_Enable = 1'b1;
        bus.RB_Enable = 1'b1;
        state_d       = (bus.InstrClass == CLS_ILLEGAL) ? HALT : S3;
      end

      S3: begin
        bus.RZ_Enable  = 1'b1;
        bus.RM_Enable  = 1'b1;
        bus.B_Select   = (bus.InstrClass == CLS_ALU_IMM) ||
                         (bus.InstrClass == CLS_LOAD) ||
                         (bus.InstrClass == CLS_STORE);
        bus.CCR_Enable = (bus.InstrClass == CLS_ALU_REG) ||
                         (bus.InstrClass == CLS_ALU_IMM);
        if (bus.InstrClass == CLS_BRANCH && bus.BranchTaken) begin
          bus.PC_Enable  = 1'b1;
          bus.INC_Select = 1'b1;
        end
        if (bus.InstrClass == CLS_CALL) begin
          bus.PC_Enable = 1'b1;
          bus.PC_Select = 1'b1;
        end
`ifdef CSG_MEM_TIMEOUT_EN
        stall_cnt_d = 8'd0;
`endif
        state_d = S4;
      end

      S4: begin
        state_d = S5;
        case (bus.InstrClass)
          CLS_ALU_REG, CLS_ALU_IMM: begin
            bus.RY_Enable = 1'b1;
          end
          CLS_LOAD: begin
            bus.MemRequest         = 1'b1;
            bus.MEM_Read_H_Write_L = 1'b1;
            bus.Y_Select           = 2'd1;
            bus.RY_Enable          = bus.MFC;
            mem_wait               = !bus.MFC;
          end
          CLS_STORE: begin
            bus.MemRequest = 1'b1;
            mem_wait       = !bus.MFC;
          end
          CLS_CALL: begin
            bus.RY_Enable = 1'b1;
            bus.Y_Select  = 2'd2;
          end
          default: ;
        endcase
        // Hold in S4 until memory completes
        if (mem_wait) begin
          state_d = S4;
`ifdef CSG_MEM_TIMEOUT_EN
          stall_cnt_d = stall_cnt_q + 8'd1;
          if (stall_cnt_d == 8'(TIMEOUT_CYCLES)) state_d = HALT;
`endif
        end
      end

      S5: begin
        bus.OperationFinished = 1'b1;
        case (bus.InstrClass)
          CLS_ALU_REG: begin
            bus.RF_WRITE = 1'b1;
            bus.C_Select = 2'd0;
          end
          CLS_ALU_IMM, CLS_LOAD: begin
            bus.RF_WRITE = 1'b1;
            bus.C_Select = 2'd1;
          end
          CLS_CALL: begin
            bus.RF_WRITE = 1'b1;
            bus.C_Select = 2'd2;
          end
          default: ;
        endcase
        state_d = bus.ProcessorEnable ? S1 : IDLE;
      end

      HALT: begin
        // Sticky until reset: HALT has no exit arc
        bus.Fault = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench for control_step_sequencer: per-cycle expected control
// vectors are queued as stimulus is applied and compared on the falling edge.
module tb_control_step_sequencer;

  logic clk;
  logic rst;

  control_step_sequencer_if bus ();

  control_step_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .Clock          (clk),
    .ProcessorReset (rst),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [23:0] exp_q[$];
  string       tag_q[$];

  // Observed control vector, fixed field order
  function automatic logic [23:0] obs_vec();
    return {bus.ROM_Read, bus.IR_Enable, bus.PC_Enable, bus.PC_Select, bus.INC_Select,
            bus.RA_Enable, bus.RB_Enable, bus.B_Select, bus.RZ_Enable, bus.RM_Enable,
            bus.CCR_Enable, bus.MemRequest, bus.MEM_Read_H_Write_L, bus.RY_Enable,
            bus.RF_WRITE, bus.C_Select, bus.Y_Select, bus.ClockCount,
            bus.OperationFinished, bus.Fault};
  endfunction

  // Reference model: step 0 = IDLE, 1..5 = S1..S5, 6 = HALT
  function automatic logic [23:0] exp_vec(input int step, input logic [2:0] cls,
                                          input logic bt, input logic mfc);
    logic rom, ir, pce, pcs, inc, ra, rb, bsel, rz, rm, ccr, mreq, mrw, ry, rfw, fin, flt;
    logic [1:0] csel, ysel;
    logic [2:0] cc;
    {rom, ir, pce, pcs, inc, ra, rb, bsel, rz, rm, ccr, mreq, mrw, ry, rfw, fin, flt} = '0;
    csel = 2'd0; ysel = 2'd0; cc = 3'd0;
    case (step)
      1: begin rom = 1; ir = 1; pce = 1; cc = 3'd1; end
      2: begin ra = 1; rb = 1; cc = 3'd2; end
      3: begin
        rz = 1; rm = 1; cc = 3'd3;
        bsel = (cls == 3'd1 || cls == 3'd2 || cls == 3'd3);
        ccr  = (cls == 3'd0 || cls == 3'd1);
        if (cls == 3'd4 && bt) begin pce = 1; inc = 1; end
        if (cls == 3'd5) begin pce = 1; pcs = 1; end
      end
      4: begin
        cc = 3'd4;
        if (cls == 3'd0 || cls == 3'd1) ry = 1;
        if (cls == 3'd2) begin mreq = 1; mrw = 1; ysel = 2'd1; ry = mfc; end
        if (cls == 3'd3) mreq = 1;
        if (cls == 3'd5) begin ry = 1; ysel = 2'd2; end
      end
      5: begin
        cc = 3'd5; fin = 1;
        rfw = (cls == 3'd0 || cls == 3'd1 || cls == 3'd2 || cls == 3'd5);
        if (cls == 3'd1 || cls == 3'd2) csel = 2'd1;
        if (cls == 3'd5) csel = 2'd2;
      end
      6: flt = 1;
      default: ;
    endcase
    return {rom, ir, pce, pcs, inc, ra, rb, bsel, rz, rm, ccr, mreq, mrw, ry, rfw,
            csel, ysel, cc, fin, flt};
  endfunction

  task automatic push_exp(input int step, input string tag);
    exp_q.push_back(exp_vec(step, bus.InstrClass, bus.BranchTaken, bus.MFC));
    tag_q.push_back($sformatf("%s_s%0d", tag, step));
  endtask

  task automatic pop_check();
    logic [23:0] e, o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = obs_vec();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %06h expected %06h", t, o, e);
    end
  endtask

  // Immediate check at the current time
  task automatic check_now(input int step, input string tag);
    push_exp(step, tag);
    pop_check();
  endtask

  // One clock cycle: queue expectation, compare mid-cycle, advance past next edge
  task automatic cycle(input int step, input string tag);
    push_exp(step, tag);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in S1; k = S4 cycles without MFC for memory classes
  task automatic run_instr(input logic [2:0] cls, input logic bt, input int k,
                           input logic mfc_noise, input string tag);
    bus.InstrClass  = cls;
    bus.BranchTaken = bt;
    bus.MFC         = mfc_noise;
    cycle(1, tag);
    cycle(2, tag);
    cycle(3, tag);
    if (cls == 3'd2 || cls == 3'd3) begin
      bus.MFC = 1'b0;
      for (int i = 0; i < k; i++) cycle(4, tag);
      bus.MFC = 1'b1;
      cycle(4, tag);
      bus.MFC = mfc_noise;
    end else begin
      cycle(4, tag);
    end
    cycle(5, tag);
    bus.MFC = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                 = 1'b1;
    bus.ProcessorEnable = 1'b0;
    bus.InstrClass      = 3'd0;
    bus.BranchTaken     = 1'b0;
    bus.MFC             = 1'b0;
    #2;
    check_now(0, "reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, "idle_off");
    bus.ProcessorEnable = 1'b1;
    cycle(0, "idle_go");

    // Back-to-back ALU instructions, then the main classes
    run_instr(3'd0, 1'b0, 0, 1'b0, "alureg_a");
    run_instr(3'd0, 1'b0, 0, 1'b0, "alureg_b");
    run_instr(3'd1, 1'b0, 0, 1'b0, "aluimm");
    run_instr(3'd2, 1'b0, 3, 1'b0, "load_k3");
    run_instr(3'd3, 1'b0, 0, 1'b0, "store_k0");
    run_instr(3'd2, 1'b0, 0, 1'b0, "load_k0");
    run_instr(3'd4, 1'b1, 0, 1'b0, "br_taken");
    run_instr(3'd4, 1'b0, 0, 1'b0, "br_not");
    run_instr(3'd5, 1'b0, 0, 1'b0, "call");
    run_instr(3'd6, 1'b0, 0, 1'b1, "nop_mfc");
    run_instr(3'd0, 1'b0, 0, 1'b1, "alu_mfc");

    // Run switch drops while the instruction is in flight
    bus.ProcessorEnable = 1'b0;
    run_instr(3'd3, 1'b0, 2, 1'b0, "store_stop");
    cycle(0, "stopped");
    cycle(0, "stopped");
    bus.ProcessorEnable = 1'b1;
    cycle(0, "restart");

    // Illegal class halts and stays halted
    bus.InstrClass = 3'd7;
    cycle(1, "illegal");
    cycle(2, "illegal");
    for (int i = 0; i < 20; i++) cycle(6, "halt");
    #2;
    rst = 1'b1;
    #1;
    check_now(0, "halt_rst");
    bus.ProcessorEnable = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, "post_halt");
    bus.ProcessorEnable = 1'b1;
    cycle(0, "go2");

    // Asynchronous reset in the middle of a LOAD stall
    bus.InstrClass = 3'd2;
    bus.MFC        = 1'b0;
    cycle(1, "ld_rst");
    cycle(2, "ld_rst");
    cycle(3, "ld_rst");
    cycle(4, "ld_rst");
    cycle(4, "ld_rst");
    #2;
    rst = 1'b1;
    #1;
    check_now(0, "stall_rst");
    bus.ProcessorEnable = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, "post_stall");
    bus.ProcessorEnable = 1'b1;
    cycle(0, "go3");
    run_instr(3'd1, 1'b0, 0, 1'b0, "after_rst");

`ifdef CSG_MEM_TIMEOUT_EN
    // STORE never completes: 15 stall cycles then HALT
    bus.InstrClass = 3'd3;
    bus.MFC        = 1'b0;
    cycle(1, "to_store");
    cycle(2, "to_store");
    cycle(3, "to_store");
    for (int i = 0; i < 15; i++) cycle(4, "to_stall");
    for (int i = 0; i < 3; i++) cycle(6, "to_halt");
    #2;
    rst = 1'b1;
    #1;
    check_now(0, "to_rst");
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
